// File: rtl/word_store_unit_if.sv
// Request/memory-side bus for word_store_unit: one 16-bit word is written as two byte stores.
// The master modport is the requester/memory side and the slave modport is the store unit.
interface word_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  Start;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [15:0]           Data;
  logic                  Ready;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [7:0]            MemData;
  logic                  MemWrite;
  logic                  Busy;
  logic                  Done;

  modport master (
    output Start, Addr, Data, Ready,
    input  MemAddr, MemData, MemWrite, Busy, Done
  );

  modport slave (
    input  Start, Addr, Data, Ready,
    output MemAddr, MemData, MemWrite, Busy, Done
  );
endinterface

// File: rtl/word_store_unit.sv
// Stores one 16-bit word as two consecutive byte writes with a Ready handshake.
// Optional macro HIGH_BYTE_FIRST_EN selects big-endian byte order (default little-endian).
module word_store_unit #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input logic             Clock,
  input logic             Reset,
  word_store_unit_if.slave bus
);

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_FIRST  = 2'd1,
    WR_SECOND = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [BYTE_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    mem_write_q, mem_write_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [BYTE_WIDTH-1:0]   first_byte;
  logic [BYTE_WIDTH-1:0]   second_byte;
  logic [ADDR_WIDTH-1:0]   addr_next;

  // Next state and latched request; Start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          addr_d  = bus.Addr;
          data_d  = bus.Data;
          state_d = WR_FIRST;
        end
      end
      WR_FIRST:  if (bus.Ready) state_d = WR_SECOND;
      WR_SECOND: if (bus.Ready) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Byte order is fixed at build time
  always_comb begin
`ifdef HIGH_BYTE_FIRST_EN
    first_byte  = data_d[15:8];
    second_byte = data_d[7:0];
`else
    first_byte  = data_d[7:0];
    second_byte = data_d[15:8];
`endif
    addr_next = addr_d + ADDR_WIDTH'(1);
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_comb begin
    mem_write_d = 1'b0;
    mem_addr_d  = addr_d;
    mem_data_d  = 8'h00;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    case (state_d)
      WR_FIRST: begin
        mem_write_d = 1'b1;
        mem_data_d  = first_byte;
      end
      WR_SECOND: begin
        mem_write_d = 1'b1;
        mem_addr_d  = addr_next;
        mem_data_d  = second_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.MemAddr  = mem_addr_q;
  assign bus.MemData  = mem_data_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule
